// File: rtl/npu_wb_master.sv
// npu_wb_master: Wishbone initiator that loads weights, streams vectors and drains results for the NPU.
// Optional ack timeout is compiled in by defining NPU_WBM_TIMEOUT_EN.
module npu_wb_master #(
   parameter logic [23:0] W_ADDRESS   = 24'h3000_00,
   parameter logic [23:0] S_ADDRESS   = 24'h3000_01,
   parameter logic [23:0] R_ADDRESS   = 24'h3000_02,
   parameter int          DWIDTH      = 24,
   parameter logic [7:0]  R_FIRST     = 8'd1,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start_i,
   input  logic [7:0]        n_vec_i,
   input  logic [7:0]        n_res_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              w_valid_i,
   input  logic [DWIDTH-1:0] w_data_i,
   output logic              w_ready_o,
   input  logic              x_valid_i,
   input  logic [DWIDTH-1:0] x_data_i,
   output logic              x_ready_o,
   output logic              r_valid_o,
   output logic [31:0]       r_data_o,
   input  logic              r_ready_i,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [31:0]       wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [31:0]       wbm_dat_i
);
   typedef enum logic [2:0] {S_IDLE, S_ACC, S_BUS, S_GAP, S_RWAIT, S_DONE} state_t;
   typedef enum logic [1:0] {P_LOAD, P_STREAM, P_DRAIN} phase_t;
   state_t      r_state;
   phase_t      r_phase;
   logic [7:0]  r_cnt, r_nvec, r_nres;
   logic        r_busy, r_done, r_cyc, r_stb, r_we, r_rvalid;
   logic [31:0] r_adr, r_dat, r_rdata;
   logic        w_wacc, w_xacc, w_wdone, w_sdone, w_to_stream;
   logic [7:0]  w_cnt_nx;
`ifdef NPU_WBM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_tcnt;
   logic          r_err;
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif
   assign w_wacc      = r_state == S_ACC && r_phase == P_LOAD && w_valid_i;
   assign w_xacc      = r_state == S_ACC && r_phase == P_STREAM && x_valid_i;
   assign w_wdone     = r_phase == P_LOAD && r_cnt == 8'd9;
   assign w_sdone     = r_phase == P_STREAM && r_cnt == r_nvec;
   assign w_to_stream = w_wdone && r_nvec != 8'd0;
   assign w_cnt_nx    = r_cnt + 8'd1;
   assign w_ready_o   = w_wacc;
   assign x_ready_o   = w_xacc;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign r_valid_o   = r_rvalid;
   assign r_data_o    = r_rdata;
   assign wbm_cyc_o   = r_cyc;
   assign wbm_stb_o   = r_stb;
   assign wbm_we_o    = r_we;
   assign wbm_sel_o   = 4'hF;
   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_phase  <= P_LOAD;
         r_cnt    <= '0;
         r_nvec   <= '0;
         r_nres   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cyc    <= 1'b0;
         r_stb    <= 1'b0;
         r_we     <= 1'b0;
         r_rvalid <= 1'b0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_rdata  <= '0;
`ifdef NPU_WBM_TIMEOUT_EN
         r_tcnt   <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
               if (start_i) begin
                  r_nvec  <= n_vec_i;
                  r_nres  <= n_res_i;
                  r_cnt   <= '0;
                  r_phase <= P_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= S_ACC;
`ifdef NPU_WBM_TIMEOUT_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            // ACC doubles as the mandatory idle cycle before every strobe
            S_ACC: if (r_phase == P_DRAIN || w_wacc || w_xacc) begin
               r_cyc   <= 1'b1;
               r_stb   <= 1'b1;
               r_we    <= r_phase != P_DRAIN;
               r_adr   <= r_phase == P_LOAD ? {W_ADDRESS, r_cnt[5:0], 2'b00} :
                          r_phase == P_STREAM ? {S_ADDRESS, 8'h00} : {R_ADDRESS, R_FIRST + r_cnt};
               r_dat   <= {{(32-DWIDTH){1'b0}}, r_phase == P_LOAD ? w_data_i : x_data_i};
               r_state <= S_BUS;
`ifdef NPU_WBM_TIMEOUT_EN
               r_tcnt  <= '0;
`endif
            end
            S_BUS: if (wbm_ack_i) begin
               r_cyc <= 1'b0;
               r_stb <= 1'b0;
               if (r_phase == P_DRAIN) begin
                  r_rdata  <= wbm_dat_i;
                  r_rvalid <= 1'b1;
                  r_state  <= S_RWAIT;
               end else begin
                  r_cnt   <= w_cnt_nx;
                  r_state <= S_GAP;
               end
            end
`ifdef NPU_WBM_TIMEOUT_EN
            else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_err   <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end else r_tcnt <= r_tcnt + 1'b1;
`endif
            S_GAP: begin
               r_state <= S_ACC;
               if (w_wdone || w_sdone) begin
                  r_cnt   <= '0;
                  r_phase <= w_to_stream ? P_STREAM : P_DRAIN;
                  if (!w_to_stream && r_nres == 8'd0) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_RWAIT: if (r_ready_i) begin
               r_rvalid <= 1'b0;
               r_cnt    <= w_cnt_nx;
               if (w_cnt_nx == r_nres) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else r_state <= S_ACC;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_npu_wb_master.sv
// tb_npu_wb_master: randomized jobs checked against a transaction-level model of the expected bus traffic.
module tb_npu_wb_master;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  n_vec = '0, n_res = '0;
   logic        busy, done, err;
   logic        w_valid = 1'b0, x_valid = 1'b0, r_ready = 1'b0;
   logic [23:0] w_data = '0, x_data = '0;
   logic        w_ready, x_ready, r_valid;
   logic [31:0] r_data;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o;
   logic        ack = 1'b0;
   logic [31:0] dat_i = '0;
   always #5 clk = ~clk;

   npu_wb_master dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .n_vec_i(n_vec), .n_res_i(n_res),
      .busy_o(busy), .done_o(done), .err_o(err),
      .w_valid_i(w_valid), .w_data_i(w_data), .w_ready_o(w_ready),
      .x_valid_i(x_valid), .x_data_i(x_data), .x_ready_o(x_ready),
      .r_valid_o(r_valid), .r_data_o(r_data), .r_ready_i(r_ready),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i)
   );

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Shared between the stimulus (main) and the bus/stream model (bfm); each variable has one writer.
   logic [23:0] wq[9];
   logic [23:0] xq[256];
   logic [64:0] obs_q[$];
   logic [31:0] rd_q[$], res_q[$];
   int widx = 0, xidx = 0, done_cnt = 0, proto_err = 0, seen_job = 0;
   int job_id = 0, job_nv = 0, lat_max = 0, bubble = 100, rdy_pct = 0;
   bit extra_ack = 0, no_ack = 0, sink_block = 0;

   initial begin : bfm
      bit w_hs, x_hs, r_hs, real_ack, in_txn;
      int lat;
      logic [64:0] held, cur;
      real_ack = 0; in_txn = 0; lat = 0; held = '0;
      forever begin
         @(negedge clk);
         w_hs = w_valid && w_ready;
         x_hs = x_valid && x_ready;
         r_hs = r_valid && r_ready;
         if ((w_ready && !w_valid) || (x_ready && !x_valid)) proto_err++;
         if (r_valid && stb) proto_err++;
         if (done && busy) proto_err++;
         if (done) done_cnt++;
         if (r_hs) res_q.push_back(r_data);
         if (cyc && stb) begin
            cur = {we, adr, we ? dat_o : 32'h0};
            if (real_ack) proto_err++;
            if (!in_txn) begin
               in_txn = 1; held = cur; lat = $urandom_range(lat_max, 0);
            end else if (cur != held) proto_err++;
            if (no_ack || lat > 0) begin
               ack = 0; real_ack = 0;
               if (lat > 0) lat--;
            end else begin
               ack = 1; real_ack = 1; in_txn = 0; dat_i = $urandom;
               obs_q.push_back(cur);
               if (!we) rd_q.push_back(dat_i);
            end
         end else begin
            ack = extra_ack && real_ack;
            real_ack = 0; in_txn = 0;
         end
         @(posedge clk); #1;
         if (seen_job != job_id) begin
            seen_job = job_id; widx = 0; xidx = 0; done_cnt = 0; proto_err = 0;
            obs_q.delete(); rd_q.delete(); res_q.delete();
         end else begin
            widx += int'(w_hs);
            xidx += int'(x_hs);
         end
         w_valid = widx < 9 && $urandom_range(99, 0) >= bubble;
         w_data  = wq[widx < 9 ? widx : 8];
         x_valid = xidx < job_nv && $urandom_range(99, 0) >= bubble;
         x_data  = xq[xidx & 255];
         r_ready = !sink_block && $urandom_range(99, 0) < rdy_pct;
      end
   end

   task automatic kick(input int nv, input int nr);
      @(negedge clk);
      job_nv = nv;
      job_id++;
      @(posedge clk); #2;
      n_vec = 8'(nv); n_res = 8'(nr); start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic run_job(input int nv, input int nr, input bit mid_start, input bit hold);
      logic [64:0] exp_q[$];
      logic [31:0] hv;
      int cyc_n, budget;
      bit held;
      for (int i = 0; i < 9; i++) exp_q.push_back({1'b1, 24'h300000, 8'(i * 4), 8'h00, wq[i]});
      for (int j = 0; j < nv; j++) exp_q.push_back({1'b1, 24'h300001, 16'h0000, xq[j]});
      for (int k = 0; k < nr; k++) exp_q.push_back({1'b0, 24'h300002, 8'(1 + k), 32'h0});
      sink_block = hold;
      kick(nv, nr);
      budget = 100 + (9 + nv + nr) * 40;
      cyc_n = 0; held = 0;
      while (done_cnt == 0 && cyc_n < budget) begin
         @(negedge clk);
         cyc_n++;
         if (mid_start && cyc_n == 6) begin
            start = 1'b1; n_vec = 8'd7; n_res = 8'd7;
            @(negedge clk);
            start = 1'b0;
         end
         if (hold && !held && r_valid) begin
            held = 1; hv = r_data;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk($sformatf("hold_valid%0d", c), r_valid, 1'b1);
               chk($sformatf("hold_data%0d", c), r_data, hv);
               chk($sformatf("hold_stb%0d", c), stb, 1'b0);
            end
            sink_block = 0;
         end
      end
      chk("done_in_time", cyc_n < budget, 1'b1);
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("busy_after", busy, 1'b0);
      chk("err_after", err, 1'b0);
      chk("beats", obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk($sformatf("beat%0d", i), obs_q[i], exp_q[i]);
      chk("w_accepts", widx, 9);
      chk("x_accepts", xidx, nv);
      chk("results", res_q.size(), nr);
      for (int i = 0; i < res_q.size() && i < rd_q.size(); i++) chk($sformatf("rdat%0d", i), res_q[i], rd_q[i]);
      chk("protocol", proto_err, 0);
   endtask

   task automatic rand_fill();
      for (int i = 0; i < 9; i++) wq[i] = 24'($urandom);
      for (int i = 0; i < 256; i++) xq[i] = 24'($urandom);
   endtask

   initial begin : main
      int cyc_n;
      rand_fill();
      repeat (3) @(negedge clk);
      chk("rst_outputs", {busy, done, err, w_ready, x_ready, r_valid, r_data, cyc, stb, we, adr, dat_o}, 0);
      chk("rst_sel", sel, 4'hF);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", c), {cyc, stb, busy, done}, 0);
      end
      // directed job: weights 1..9, two vectors, three reads
      for (int i = 0; i < 9; i++) wq[i] = 24'(i + 1);
      bubble = 0; rdy_pct = 100; lat_max = 0;
      run_job(2, 3, 0, 0);
      rand_fill(); bubble = 20; rdy_pct = 70; lat_max = 1;
      run_job(1, 2, 0, 1);
      rand_fill(); extra_ack = 1; lat_max = 2;
      run_job(3, 2, 0, 0);
      extra_ack = 0; rand_fill();
      run_job(0, 0, 1, 0);
      rand_fill(); bubble = 0; rdy_pct = 100; lat_max = 0;
      run_job(1, 255, 0, 0);
      for (int t = 0; t < 4; t++) begin
         rand_fill();
         bubble = $urandom_range(50, 0); rdy_pct = $urandom_range(100, 30);
         lat_max = $urandom_range(3, 0); extra_ack = 1'($urandom);
         run_job($urandom_range(6, 0), $urandom_range(6, 0), 0, 0);
      end
      extra_ack = 0; bubble = 0; rdy_pct = 100; lat_max = 0;
      // silent slave
      no_ack = 1;
      kick(0, 0);
      cyc_n = 0;
      while (!stb && cyc_n < 50) begin @(negedge clk); cyc_n++; end
      chk("stb_seen", stb, 1'b1);
`ifdef NPU_WBM_TIMEOUT_EN
      cyc_n = 0;
      while (done_cnt == 0 && cyc_n < 400) begin @(negedge clk); cyc_n++; end
      chk("to_done", done_cnt, 1);
      chk("to_err", err, 1'b1);
      chk("to_stb", stb, 1'b0);
`else
      repeat (300) @(negedge clk);
      chk("hang_busy", busy, 1'b1);
      chk("hang_stb", stb, 1'b1);
      chk("hang_done", done_cnt, 0);
      chk("hang_err", err, 1'b0);
`endif
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_bus", {cyc, stb, busy}, 0);
      rst = 1'b0; no_ack = 0;
      // reset while a result is held
      sink_block = 1;
      kick(0, 1);
      cyc_n = 0;
      while (!r_valid && cyc_n < 200) begin @(negedge clk); cyc_n++; end
      chk("rv_seen", r_valid, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rv_discard", {r_valid, r_data, busy}, 0);
      rst = 1'b0;
      rand_fill();
      run_job(1, 1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
